// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers responses for decode; data reaches valid_o one cycle after rvalid.
// Backpressure: ready_i low holds the head; requests stop once in-flight plus buffered entries reach FIFO_DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i
);
    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   tag_mem   [FIFO_DEPTH];
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];

    logic          grant;
    logic          rsp;
    logic          keep;
    logic          pop;
    logic          head_leaving;
    logic [CW:0]   in_use;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A head accepted this cycle frees its credit now, sustaining one fetch per cycle.
    assign head_leaving = valid_o && ready_i;
    assign in_use       = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, head_leaving};
    assign imem_req_o   = rst_n_i && !redirect_i && (in_use < DEPTH_W);
    assign imem_addr_o  = pc;

    assign grant = imem_req_o && imem_gnt_i;
    assign rsp   = imem_rvalid_i;
    assign keep  = rsp && (discard == '0) && !redirect_i;
    assign pop   = head_leaving && !redirect_i;

    assign valid_o = (count != '0);
    assign instr_o = valid_o ? instr_mem[rd_ptr] : NOP_INSTR;
    assign pc_o    = valid_o ? pc_mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (grant) begin
                pc     <= pc + 32'd4;
                tag_wr <= ptr_inc(tag_wr);
            end
            if (rsp) begin
                tag_rd <= ptr_inc(tag_rd);
            end
            if (redirect_i) begin
                // Tag queue is not flushed: stale responses still return and pop their tags.
                pc      <= redirect_pc_i & ~32'h3;
                discard <= outstanding - CW'(rsp);
                count   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (rsp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (keep) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) begin
            tag_mem[tag_wr] <= pc;
        end
        if (keep) begin
            pc_mem[wr_ptr]    <= tag_mem[tag_rd];
            instr_mem[wr_ptr] <= imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus a queue-level fetch model checked every cycle.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    // fetch model: program counter, in-flight tags, buffered {pc, instr}
    logic [31:0] m_pc;
    int          m_out;
    int          m_disc;
    logic [31:0] m_tags[$];
    logic [63:0] m_fifo[$];
    mreq_t       mem_q[$];
    int          cyc;

    int p_ready, p_gnt, p_rv, p_redir, max_lat, gnt_delay, hold_cnt;
    int          redir_arm;
    logic [31:0] redir_tgt;
    logic [31:0] lit_pc;
    logic        lit_pending;
    logic [31:0] exp_next;
    logic        prev_req_wait;
    logic [31:0] prev_addr;
    logic        last_req;
    logic [31:0] acc_pc[$];
    int          acc_cyc[$];

    task automatic step();
        logic        m_req, m_pop, grant, rsp, redir;
        logic [63:0] head;
        logic [31:0] tag;
        @(negedge clk);
        chk("valid_o", 32'(valid_o), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            head = m_fifo[0];
            chk("pc_o", pc_o, head[63:32]);
            chk("instr_o", instr_o, head[31:0]);
        end else begin
            chk("instr_o_empty", instr_o, NOP);
            chk("pc_o_empty", pc_o, 32'h0);
        end

        ready_i = ($urandom_range(0, 99) < p_ready);
        rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && ($urandom_range(0, 99) < p_rv);
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        redir = ($urandom_range(0, 999) < p_redir);
        redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        if ((redir_arm == 1 && m_out == 1 && m_fifo.size() == 1) ||
            (redir_arm == 2 && rsp && m_fifo.size() != 0)) begin
            redir = 1'b1;
            ready_i = 1'b1;
            redirect_pc_i = redir_tgt;
            redir_arm = 0;
            lit_pending = 1'b1;
        end
        redirect_i = redir;

        m_pop = (m_fifo.size() != 0) && ready_i;
        m_req = !redir && ((m_out + m_fifo.size() - int'(m_pop)) < DEPTH);
        if (gnt_delay > 0) imem_gnt_i = m_req && (hold_cnt >= gnt_delay);
        else               imem_gnt_i = ($urandom_range(0, 99) < p_gnt);
        #1;
        chk("imem_req_o", 32'(imem_req_o), 32'(m_req));
        last_req = imem_req_o;
        if (m_req) chk("imem_addr_o", imem_addr_o, m_pc);
        if (m_req && prev_req_wait) chk("addr_held", imem_addr_o, prev_addr);
        grant = m_req && imem_gnt_i;
        prev_req_wait = m_req && !imem_gnt_i;
        prev_addr = m_pc;
        hold_cnt = prev_req_wait ? hold_cnt + 1 : 0;

        if (m_pop && !redir) begin
            chk("stream_pc", pc_o, exp_next);
            chk("stream_instr", instr_o, mem_word(exp_next));
            if (lit_pending) begin
                chk("redirect_target", pc_o, lit_pc);
                lit_pending = 1'b0;
            end
            acc_pc.push_back(pc_o);
            acc_cyc.push_back(cyc);
            exp_next += 32'd4;
        end

        @(posedge clk);
        if (m_pop && !redir) void'(m_fifo.pop_front());
        if (redir) begin
            m_disc = m_out - int'(rsp);
            m_fifo.delete();
            m_pc = redirect_pc_i & ~32'h3;
            exp_next = m_pc;
        end
        if (rsp) begin
            tag = m_tags.pop_front();
            void'(mem_q.pop_front());
            m_out--;
            if (!redir) begin
                if (m_disc > 0) m_disc--;
                else m_fifo.push_back({tag, imem_rdata_i});
            end
        end
        if (grant) begin
            m_tags.push_back(m_pc);
            mem_q.push_back('{m_pc, cyc + 1 + int'($urandom_range(0, max_lat))});
            m_out++;
            m_pc += 32'd4;
        end
        cyc++;
    endtask

    // Called at time 0 or right after a step's model update, so no edge is skipped.
    task automatic do_reset(input bit mid);
        #3;
        rst_n = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i = 1'b0;
        ready_i = 1'b0;
        #1;
        if (mid) begin
            chk("rst_valid_o", 32'(valid_o), 32'h0);
            chk("rst_req_o", 32'(imem_req_o), 32'h0);
            chk("rst_instr_o", instr_o, NOP);
            chk("rst_pc_o", pc_o, 32'h0);
        end
        m_pc = RESET_PC; m_out = 0; m_disc = 0;
        m_tags.delete(); m_fifo.delete(); mem_q.delete();
        exp_next = RESET_PC; prev_req_wait = 1'b0; hold_cnt = 0;
        lit_pending = 1'b0; redir_arm = 0; cyc = 0;
        acc_pc.delete(); acc_cyc.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic knobs(input int r, input int g, input int v, input int lat, input int rd);
        p_ready = r; p_gnt = g; p_rv = v; max_lat = lat; p_redir = rd; gnt_delay = 0;
    endtask

    initial begin
        int start;
        knobs(100, 100, 100, 0, 0);
        do_reset(1'b0);

        // sequential fetch with single-cycle memory
        repeat (12) step();
        chk("seq_enough", 32'(acc_pc.size() >= 3), 32'h1);
        if (acc_pc.size() >= 3) begin
            chk("seq_pc0", acc_pc[0], 32'h0000_0100);
            chk("seq_pc1", acc_pc[1], 32'h0000_0104);
            chk("seq_pc2", acc_pc[2], 32'h0000_0108);
            chk("seq_cyc0", 32'(acc_cyc[0]), 32'd2);
            chk("seq_cyc1", 32'(acc_cyc[1]), 32'd3);
            chk("seq_cyc2", 32'(acc_cyc[2]), 32'd4);
        end

        // backpressure for 6 cycles, then release
        knobs(0, 100, 100, 0, 0);
        repeat (6) step();
        chk("bp_req_dropped", 32'(last_req), 32'h0);
        chk("bp_valid_held", 32'(valid_o), 32'h1);
        knobs(100, 100, 100, 0, 0);
        repeat (10) step();

        // redirect with one in flight and one buffered
        knobs(50, 70, 70, 2, 0);
        redir_tgt = 32'h0000_0200; lit_pc = 32'h0000_0200; redir_arm = 1;
        for (int i = 0; i < 800 && redir_arm != 0; i++) step();
        chk("redirA_fired", 32'(redir_arm), 32'h0);
        for (int i = 0; i < 300 && lit_pending; i++) step();
        chk("redirA_seen", 32'(lit_pending), 32'h0);

        // redirect coincident with rvalid, ready high, unaligned target
        redir_tgt = 32'h0000_020B; lit_pc = 32'h0000_0208; redir_arm = 2;
        for (int i = 0; i < 800 && redir_arm != 0; i++) step();
        chk("redirB_fired", 32'(redir_arm), 32'h0);
        for (int i = 0; i < 300 && lit_pending; i++) step();
        chk("redirB_seen", 32'(lit_pending), 32'h0);

        // grant withheld three cycles each time
        knobs(100, 0, 100, 1, 0);
        gnt_delay = 3;
        start = acc_pc.size();
        repeat (40) step();
        chk("slow_gnt_progress", 32'(acc_pc.size() > start), 32'h1);

        // random traffic with redirects (targets often near the top of memory)
        knobs(60, 60, 60, 3, 40);
        repeat (3000) step();
        knobs(100, 100, 100, 0, 0);
        repeat (20) step();

        // async reset while the buffer is full
        knobs(0, 100, 100, 0, 0);
        for (int i = 0; i < 50 && m_fifo.size() != DEPTH; i++) step();
        chk("fill_reached", 32'(m_fifo.size()), 32'(DEPTH));
        chk("fill_valid", 32'(valid_o), 32'h1);
        do_reset(1'b1);
        knobs(100, 100, 100, 0, 0);
        repeat (10) step();
        chk("post_rst_enough", 32'(acc_pc.size() >= 1), 32'h1);
        if (acc_pc.size() >= 1) chk("post_rst_pc", acc_pc[0], 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
